odd_operand_fetch: RTL and testbench

//  Operand-fetch / issue stage directly upstream of the odd pipe (permute, load/store, branch).

---
 rtl/odd_operand_fetch_pkg.sv | 69 ++++++
 rtl/odd_operand_fetch_fwd_mux.sv | 56 +++++
 rtl/odd_operand_fetch.sv | 212 +++++++++++++++++++++
 tb/tb_odd_operand_fetch.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/odd_operand_fetch_pkg.sv
// Shared types and constants for the odd-pipe operand-fetch stage: packed forwarding-bus
// layout, hold-entry and stage-1 bundle structs, and the bubble value.
package odd_operand_fetch_pkg;

  localparam int unsigned DW  = 128;
  localparam int unsigned AW  = 7;
  localparam int unsigned PKW = 143;

  // Packed stage bus: [2:0] unit, [130:3] result, [137:131] dst, [141:138] latency, [142] wr
  localparam int unsigned PkUnitLsb = 0;
  localparam int unsigned PkUnitW   = 3;
  localparam int unsigned PkResLsb  = 3;
  localparam int unsigned PkDstLsb  = 131;
  localparam int unsigned PkLatLsb  = 138;
  localparam int unsigned LatW      = 4;
  localparam int unsigned PkWrBit   = 142;

  localparam int unsigned NumPkStages  = 6;
  localparam int          FirstPkStage = 2;

  localparam logic [6:0] instr_ID_lnop = 7'd1;

  typedef enum logic {StEmpty, StHeld} state_e;

  typedef struct packed {
    logic [31:0]   full_instr;
    logic [6:0]    instr_id;
    logic [2:0]    unit_id;
    logic [3:0]    latency;
    logic          reg_wr;
    logic [AW-1:0] reg_dst;
    logic [AW-1:0] ra_addr;
    logic [AW-1:0] rb_addr;
    logic [AW-1:0] rc_addr;
    logic          use_ra;
    logic          use_rb;
    logic          use_rc;
    logic [6:0]    imme7;
    logic [9:0]    imme10;
    logic [15:0]   imme16;
    logic [17:0]   imme18;
    logic [9:0]    pc;
  } entry_t;

  typedef struct packed {
    logic [31:0]   full_instr;
    logic [6:0]    instr_id;
    logic [2:0]    unit_id;
    logic [3:0]    latency;
    logic          reg_wr;
    logic [AW-1:0] reg_dst;
    logic [DW-1:0] ra_data;
    logic [DW-1:0] rb_data;
    logic [DW-1:0] rc_data;
    logic [6:0]    imme7;
    logic [9:0]    imme10;
    logic [15:0]   imme16;
    logic [17:0]   imme18;
    logic [9:0]    pc;
  } bundle_t;

  function automatic bundle_t bubble_bundle();
    bundle_t b;
    b          = '0;
    b.instr_id = instr_ID_lnop;
    return b;
  endfunction

endpackage

// File: rtl/odd_operand_fetch_fwd_mux.sv
// Per-source operand select: youngest producer wins; a producer whose result is not yet
// available (stage 1, or packed stage earlier than its latency) raises a hazard instead.
module odd_operand_fetch_fwd_mux
  import odd_operand_fetch_pkg::*;
(
  input  logic                       use_src,
  input  logic [AW-1:0]              src_addr,
  input  logic                       s1_wr,
  input  logic [AW-1:0]              s1_dst,
  input  logic [NumPkStages*PKW-1:0] packed_flat,
  input  logic                       wb_en,
  input  logic [AW-1:0]              wb_addr,
  input  logic [DW-1:0]              wb_data,
  input  logic [DW-1:0]              rf_data,
  output logic [DW-1:0]              fwd_data,
  output logic                       hazard
);

  logic found;

  // Index 0 of packed_flat is stage 2; lower index is younger.
  always_comb begin
    fwd_data = '0;
    hazard   = 1'b0;
    found    = 1'b0;
    if (use_src) begin
      if (s1_wr && (s1_dst == src_addr)) begin
        hazard = 1'b1;
        found  = 1'b1;
      end
      for (int n = 0; n < int'(NumPkStages); n++) begin
        if (!found && packed_flat[n*PKW + PkWrBit] &&
            (packed_flat[n*PKW + PkDstLsb +: AW] == src_addr)) begin
          found = 1'b1;
          if (int'(packed_flat[n*PKW + PkLatLsb +: LatW]) <= n + FirstPkStage) begin
            fwd_data = packed_flat[n*PKW + PkResLsb +: DW];
          end else begin
            hazard = 1'b1;
          end
        end
      end
      if (!found) begin
        fwd_data = (wb_en && (wb_addr == src_addr)) ? wb_data : rf_data;
      end
    end
  end

  logic unused_unit;
  assign unused_unit = ^{packed_flat[0*PKW + PkUnitLsb +: PkUnitW],
                         packed_flat[1*PKW + PkUnitLsb +: PkUnitW],
                         packed_flat[2*PKW + PkUnitLsb +: PkUnitW],
                         packed_flat[3*PKW + PkUnitLsb +: PkUnitW],
                         packed_flat[4*PKW + PkUnitLsb +: PkUnitW],
                         packed_flat[5*PKW + PkUnitLsb +: PkUnitW]};

endmodule

// File: rtl/odd_operand_fetch.sv
// Odd-pipe operand-fetch/issue stage: one-entry hold register, per-source forwarding with
// RAW-hazard stalls, and a registered stage-1 bundle that is a bubble on stall or flush.
module odd_operand_fetch
  import odd_operand_fetch_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_full_instr,
  input  logic [6:0]       in_instr_id,
  input  logic [2:0]       in_unit_id,
  input  logic [3:0]       in_latency,
  input  logic             in_reg_wr,
  input  logic [6:0]       in_reg_dst,
  input  logic [6:0]       in_ra_addr,
  input  logic [6:0]       in_rb_addr,
  input  logic [6:0]       in_rc_addr,
  input  logic             in_use_ra,
  input  logic             in_use_rb,
  input  logic             in_use_rc,
  input  logic [6:0]       in_imme7,
  input  logic [9:0]       in_imme10,
  input  logic [15:0]      in_imme16,
  input  logic [17:0]      in_imme18,
  input  logic [9:0]       in_pc,
  output logic [6:0]       rf_ra_addr,
  output logic [6:0]       rf_rb_addr,
  output logic [6:0]       rf_rc_addr,
  input  logic [127:0]     rf_ra_data,
  input  logic [127:0]     rf_rb_data,
  input  logic [127:0]     rf_rc_data,
  input  logic [142:0]     packed_2stage,
  input  logic [142:0]     packed_3stage,
  input  logic [142:0]     packed_4stage,
  input  logic [142:0]     packed_5stage,
  input  logic [142:0]     packed_6stage,
  input  logic [142:0]     packed_7stage,
  input  logic [6:0]       WB_reg_write_addr,
  input  logic [127:0]     WB_reg_write_data,
  input  logic             WB_reg_write_en,
  output logic [31:0]      full_instr,
  output logic [6:0]       instr_id,
  output logic [2:0]       unit_id,
  output logic [3:0]       latency,
  output logic             reg_wr,
  output logic [6:0]       reg_dst,
  output logic [127:0]     ra_data,
  output logic [127:0]     rb_data,
  output logic [127:0]     rc_data,
  output logic [6:0]       imme7,
  output logic [9:0]       imme10,
  output logic [15:0]      imme16,
  output logic [17:0]      imme18,
  output logic [9:0]       current_PC,
  output logic [CNT_W-1:0] stall_cycles
);

  state_e     state_q, state_d;
  entry_t     entry_q, in_entry;
  bundle_t    out_q, issue_bundle;
  logic [CNT_W-1:0] stall_q;

  logic [NumPkStages*PKW-1:0] packed_flat;
  logic [DW-1:0] fwd_a, fwd_b, fwd_c;
  logic haz_a, haz_b, haz_c, hazard;
  logic issue_now, stall_now, accept;

  assign packed_flat = {packed_7stage, packed_6stage, packed_5stage,
                        packed_4stage, packed_3stage, packed_2stage};

  odd_operand_fetch_fwd_mux u_fwd_ra (
    .use_src(entry_q.use_ra), .src_addr(entry_q.ra_addr),
    .s1_wr(out_q.reg_wr), .s1_dst(out_q.reg_dst), .packed_flat(packed_flat),
    .wb_en(WB_reg_write_en), .wb_addr(WB_reg_write_addr), .wb_data(WB_reg_write_data),
    .rf_data(rf_ra_data), .fwd_data(fwd_a), .hazard(haz_a)
  );

  odd_operand_fetch_fwd_mux u_fwd_rb (
    .use_src(entry_q.use_rb), .src_addr(entry_q.rb_addr),
    .s1_wr(out_q.reg_wr), .s1_dst(out_q.reg_dst), .packed_flat(packed_flat),
    .wb_en(WB_reg_write_en), .wb_addr(WB_reg_write_addr), .wb_data(WB_reg_write_data),
    .rf_data(rf_rb_data), .fwd_data(fwd_b), .hazard(haz_b)
  );

  odd_operand_fetch_fwd_mux u_fwd_rc (
    .use_src(entry_q.use_rc), .src_addr(entry_q.rc_addr),
    .s1_wr(out_q.reg_wr), .s1_dst(out_q.reg_dst), .packed_flat(packed_flat),
    .wb_en(WB_reg_write_en), .wb_addr(WB_reg_write_addr), .wb_data(WB_reg_write_data),
    .rf_data(rf_rc_data), .fwd_data(fwd_c), .hazard(haz_c)
  );

  assign hazard = haz_a | haz_b | haz_c;
  assign accept = in_valid & in_ready;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= StEmpty;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StEmpty: if (accept) state_d = StHeld;
      StHeld: begin
        if (flush) begin
          state_d = StEmpty;
        end else if (issue_now && !accept) begin
          state_d = StEmpty;
        end
      end
      default: state_d = StEmpty;
    endcase
  end

  // flush blocks both issue and capture in the same cycle.
  always_comb begin
    issue_now = 1'b0;
    stall_now = 1'b0;
    in_ready  = 1'b0;
    unique case (state_q)
      StEmpty: in_ready = rst & ~flush;
      StHeld: begin
        issue_now = ~hazard & ~flush;
        stall_now = hazard & ~flush;
        in_ready  = rst & ~hazard & ~flush;
      end
      default: ;
    endcase
  end

  always_comb begin
    in_entry            = '0;
    in_entry.full_instr = in_full_instr;
    in_entry.instr_id   = in_instr_id;
    in_entry.unit_id    = in_unit_id;
    in_entry.latency    = in_latency;
    in_entry.reg_wr     = in_reg_wr;
    in_entry.reg_dst    = in_reg_dst;
    in_entry.ra_addr    = in_ra_addr;
    in_entry.rb_addr    = in_rb_addr;
    in_entry.rc_addr    = in_rc_addr;
    in_entry.use_ra     = in_use_ra;
    in_entry.use_rb     = in_use_rb;
    in_entry.use_rc     = in_use_rc;
    in_entry.imme7      = in_imme7;
    in_entry.imme10     = in_imme10;
    in_entry.imme16     = in_imme16;
    in_entry.imme18     = in_imme18;
    in_entry.pc         = in_pc;
  end

  always_comb begin
    issue_bundle            = '0;
    issue_bundle.full_instr = entry_q.full_instr;
    issue_bundle.instr_id   = entry_q.instr_id;
    issue_bundle.unit_id    = entry_q.unit_id;
    issue_bundle.latency    = entry_q.latency;
    issue_bundle.reg_wr     = entry_q.reg_wr;
    issue_bundle.reg_dst    = entry_q.reg_dst;
    issue_bundle.ra_data    = fwd_a;
    issue_bundle.rb_data    = fwd_b;
    issue_bundle.rc_data    = fwd_c;
    issue_bundle.imme7      = entry_q.imme7;
    issue_bundle.imme10     = entry_q.imme10;
    issue_bundle.imme16     = entry_q.imme16;
    issue_bundle.imme18     = entry_q.imme18;
    issue_bundle.pc         = entry_q.pc;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      entry_q <= '0;
      out_q   <= bubble_bundle();
      stall_q <= '0;
    end else begin
      if (accept) begin
        entry_q <= in_entry;
      end
      out_q <= issue_now ? issue_bundle : bubble_bundle();
      if (stall_now && !(&stall_q)) begin
        stall_q <= stall_q + 1'b1;
      end
    end
  end

  assign rf_ra_addr   = entry_q.ra_addr;
  assign rf_rb_addr   = entry_q.rb_addr;
  assign rf_rc_addr   = entry_q.rc_addr;
  assign full_instr   = out_q.full_instr;
  assign instr_id     = out_q.instr_id;
  assign unit_id      = out_q.unit_id;
  assign latency      = out_q.latency;
  assign reg_wr       = out_q.reg_wr;
  assign reg_dst      = out_q.reg_dst;
  assign ra_data      = out_q.ra_data;
  assign rb_data      = out_q.rb_data;
  assign rc_data      = out_q.rc_data;
  assign imme7        = out_q.imme7;
  assign imme10       = out_q.imme10;
  assign imme16       = out_q.imme16;
  assign imme18       = out_q.imme18;
  assign current_PC   = out_q.pc;
  assign stall_cycles = stall_q;

endmodule

// File: tb/tb_odd_operand_fetch.sv
// Directed bench for odd_operand_fetch: a cycle model built from the forwarding/stall rules is
// compared every cycle, plus hand-computed literal checks at key points.
module tb_odd_operand_fetch;

  localparam logic [6:0] LNOP = 7'd1;

  typedef struct packed {
    logic [31:0] full;
    logic [6:0]  id;
    logic [2:0]  unit;
    logic [3:0]  lat;
    logic        wr;
    logic [6:0]  dst;
    logic [6:0]  ra, rb, rc;
    logic        ua, ub, uc;
    logic [6:0]  i7;
    logic [9:0]  i10;
    logic [15:0] i16;
    logic [17:0] i18;
    logic [9:0]  pc;
  } ins_t;

  typedef struct packed {
    ins_t         i;
    logic [127:0] a, b, c;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b0, flush = 1'b0, in_valid = 1'b0, in_ready;
  ins_t cur = '0;
  logic [6:0] rf_ra_addr, rf_rb_addr, rf_rc_addr;
  logic [127:0] rf_ra_data, rf_rb_data, rf_rc_data;
  logic [127:0] rf_mem [128];
  logic [142:0] pk [2:7];
  logic [6:0] wb_addr = '0;
  logic [127:0] wb_data = '0;
  logic wb_en = 1'b0;
  logic [31:0] full_instr;
  logic [6:0] instr_id, reg_dst, imme7;
  logic [2:0] unit_id;
  logic [3:0] latency;
  logic reg_wr;
  logic [127:0] ra_data, rb_data, rc_data;
  logic [9:0] imme10, current_PC;
  logic [15:0] imme16, stall_cycles;
  logic [17:0] imme18;

  assign rf_ra_data = rf_mem[rf_ra_addr];
  assign rf_rb_data = rf_mem[rf_rb_addr];
  assign rf_rc_data = rf_mem[rf_rc_addr];

  odd_operand_fetch dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_full_instr(cur.full), .in_instr_id(cur.id), .in_unit_id(cur.unit),
    .in_latency(cur.lat), .in_reg_wr(cur.wr), .in_reg_dst(cur.dst),
    .in_ra_addr(cur.ra), .in_rb_addr(cur.rb), .in_rc_addr(cur.rc),
    .in_use_ra(cur.ua), .in_use_rb(cur.ub), .in_use_rc(cur.uc),
    .in_imme7(cur.i7), .in_imme10(cur.i10), .in_imme16(cur.i16), .in_imme18(cur.i18),
    .in_pc(cur.pc),
    .rf_ra_addr(rf_ra_addr), .rf_rb_addr(rf_rb_addr), .rf_rc_addr(rf_rc_addr),
    .rf_ra_data(rf_ra_data), .rf_rb_data(rf_rb_data), .rf_rc_data(rf_rc_data),
    .packed_2stage(pk[2]), .packed_3stage(pk[3]), .packed_4stage(pk[4]),
    .packed_5stage(pk[5]), .packed_6stage(pk[6]), .packed_7stage(pk[7]),
    .WB_reg_write_addr(wb_addr), .WB_reg_write_data(wb_data), .WB_reg_write_en(wb_en),
    .full_instr(full_instr), .instr_id(instr_id), .unit_id(unit_id), .latency(latency),
    .reg_wr(reg_wr), .reg_dst(reg_dst), .ra_data(ra_data), .rb_data(rb_data),
    .rc_data(rc_data), .imme7(imme7), .imme10(imme10), .imme16(imme16), .imme18(imme18),
    .current_PC(current_PC), .stall_cycles(stall_cycles)
  );

  // ---------------- model ----------------
  logic        m_live = 1'b0;
  logic        m_held = 1'b0;
  ins_t        m_ent = '0;
  exp_t        m_out = '0;
  logic [15:0] m_stall = '0;

  function automatic exp_t bub();
    exp_t e;
    e      = '0;
    e.i.id = LNOP;
    return e;
  endfunction

  // {hazard, data} for one source under the youngest-producer rule
  function automatic logic [128:0] resolve(logic u, logic [6:0] r);
    if (!u) return {1'b0, 128'h0};
    if (m_out.i.wr && m_out.i.dst == r) return {1'b1, 128'h0};
    for (int n = 2; n <= 7; n++) begin
      if (pk[n][142] && pk[n][137:131] == r) begin
        if (int'(pk[n][141:138]) <= n) return {1'b0, pk[n][130:3]};
        return {1'b1, 128'h0};
      end
    end
    if (wb_en && wb_addr == r) return {1'b0, wb_data};
    return {1'b0, rf_mem[r]};
  endfunction

  function automatic logic model_hazard();
    logic [128:0] x, y, z;
    x = resolve(m_ent.ua, m_ent.ra);
    y = resolve(m_ent.ub, m_ent.rb);
    z = resolve(m_ent.uc, m_ent.rc);
    return m_held && (x[128] | y[128] | z[128]);
  endfunction

  function automatic logic model_ready();
    return rst && !flush && (!m_held || !model_hazard());
  endfunction

  always @(posedge clk) begin : model
    logic [128:0] xa, xb, xc;
    logic h, issue, rdy;
    if (!rst) begin
      m_held  = 1'b0;
      m_out   = bub();
      m_stall = '0;
      m_live  = 1'b1;
    end else begin
      xa    = resolve(m_ent.ua, m_ent.ra);
      xb    = resolve(m_ent.ub, m_ent.rb);
      xc    = resolve(m_ent.uc, m_ent.rc);
      h     = model_hazard();
      issue = m_held && !h && !flush;
      rdy   = model_ready();
      if (m_held && h && !flush && m_stall != 16'hFFFF) m_stall = m_stall + 16'd1;
      if (issue) begin
        m_out      = '0;
        m_out.i    = m_ent;
        m_out.i.ra = '0; m_out.i.rb = '0; m_out.i.rc = '0;
        m_out.i.ua = 1'b0; m_out.i.ub = 1'b0; m_out.i.uc = 1'b0;
        m_out.a    = xa[127:0];
        m_out.b    = xb[127:0];
        m_out.c    = xc[127:0];
      end else begin
        m_out = bub();
      end
      if (flush) m_held = 1'b0;
      else if (in_valid && rdy) begin
        m_held = 1'b1;
        m_ent  = cur;
      end else if (issue) m_held = 1'b0;
    end
  end

  // ---------------- checking ----------------
  int checks = 0;
  int errors = 0;
  logic last_ready;

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic compare_all();
    ins_t a;
    a      = '0;
    a.full = full_instr; a.id = instr_id; a.unit = unit_id; a.lat = latency;
    a.wr   = reg_wr; a.dst = reg_dst; a.i7 = imme7; a.i10 = imme10; a.i16 = imme16;
    a.i18  = imme18; a.pc = current_PC;
    if (m_live) begin
      chk("ctrl", a, m_out.i);
      chk("ra_data", ra_data, m_out.a);
      chk("rb_data", rb_data, m_out.b);
      chk("rc_data", rc_data, m_out.c);
      chk("stall_cycles", stall_cycles, m_stall);
      if (m_held) chk("rf_addr", {rf_ra_addr, rf_rb_addr, rf_rc_addr},
                      {m_ent.ra, m_ent.rb, m_ent.rc});
    end
    chk("in_ready", in_ready, model_ready());
  endtask

  // Called at a negedge with inputs set; checks just before the posedge, returns at next negedge.
  task automatic step();
    #3;
    compare_all();
    last_ready = in_ready;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send(input ins_t x);
    logic acc;
    cur      = x;
    in_valid = 1'b1;
    acc      = 1'b0;
    for (int k = 0; k < 20 && !acc; k++) begin
      step();
      if (last_ready) acc = 1'b1;
    end
    chk("send_accept", acc, 1'b1);
    in_valid = 1'b0;
  endtask

  function automatic ins_t mk(logic [6:0] id, logic [6:0] ra, logic ua, logic [6:0] rb,
                              logic ub, logic [6:0] rc, logic uc, logic wr,
                              logic [6:0] dst, logic [3:0] lat);
    ins_t x;
    x.full = {8'hC3, 17'h0, id};
    x.id   = id;
    x.unit = id[2:0];
    x.lat  = lat;
    x.wr   = wr;
    x.dst  = dst;
    x.ra   = ra; x.ua = ua;
    x.rb   = rb; x.ub = ub;
    x.rc   = rc; x.uc = uc;
    x.i7   = ~id;
    x.i10  = {3'b101, id};
    x.i16  = {9'h1F0, id};
    x.i18  = {11'h2AA, id};
    x.pc   = {3'b011, id};
    return x;
  endfunction

  function automatic logic [142:0] mkpk(logic w, logic [6:0] d, logic [3:0] l,
                                        logic [127:0] r);
    return {w, l, d, r, 3'b101};
  endfunction

  initial begin
    for (int i = 0; i < 128; i++) rf_mem[i] = {16{8'(i)}};
    rf_mem[5] = {16{8'hAA}};
    for (int n = 2; n <= 7; n++) pk[n] = '0;
    @(negedge clk);

    // 1. reset
    rst = 1'b0;
    step();
    step();
    chk("rst_id", instr_id, LNOP);
    chk("rst_wr", reg_wr, 1'b0);
    chk("rst_stall", stall_cycles, 16'd0);
    chk("rst_ready", in_ready, 1'b0);
    rst = 1'b1;
    #1 chk("rel_ready", in_ready, 1'b1);

    // 2. no hazard, then back-to-back
    send(mk(7'd10, 7'd5, 1'b1, 7'd6, 1'b0, 7'd8, 1'b1, 1'b0, 7'd0, 4'd1));
    step();
    chk("t2_ra", ra_data, {16{8'hAA}});
    chk("t2_rb_unused", rb_data, 128'h0);
    chk("t2_rc", rc_data, {16{8'h08}});
    chk("t2_id", instr_id, 7'd10);
    send(mk(7'd11, 7'd20, 1'b1, 7'd0, 1'b0, 7'd0, 1'b0, 1'b0, 7'd0, 4'd1));
    send(mk(7'd12, 7'd21, 1'b1, 7'd0, 1'b0, 7'd0, 1'b0, 1'b0, 7'd0, 4'd1));
    chk("b2b_id0", instr_id, 7'd11);
    chk("b2b_ra0", ra_data, {16{8'h14}});
    step();
    chk("b2b_id1", instr_id, 7'd12);

    // 3. forward from packed_4, then a not-yet-ready result
    pk[4] = mkpk(1'b1, 7'd5, 4'd4, {16{8'h11}});
    send(mk(7'd13, 7'd5, 1'b1, 7'd0, 1'b0, 7'd0, 1'b0, 1'b0, 7'd0, 4'd1));
    step();
    chk("t3_fwd", ra_data, {16{8'h11}});
    chk("t3_stall0", stall_cycles, 16'd0);
    pk[4] = mkpk(1'b1, 7'd5, 4'd6, {16{8'h11}});
    send(mk(7'd14, 7'd5, 1'b1, 7'd0, 1'b0, 7'd0, 1'b0, 1'b0, 7'd0, 4'd1));
    step();
    chk("t3_bubble", instr_id, LNOP);
    chk("t3_stall1", stall_cycles, 16'd1);
    pk[4] = '0;
    pk[6] = mkpk(1'b1, 7'd5, 4'd6, {16{8'h11}});
    step();
    chk("t3_late_fwd", ra_data, {16{8'h11}});
    chk("t3_late_id", instr_id, 7'd14);
    pk[6] = '0;

    // 4. priority among packed stages and WB
    pk[3] = mkpk(1'b1, 7'd9, 4'd3, {16{8'h33}});
    pk[6] = mkpk(1'b1, 7'd9, 4'd6, {16{8'h66}});
    wb_en = 1'b1; wb_addr = 7'd9; wb_data = {16{8'h77}};
    send(mk(7'd15, 7'd9, 1'b1, 7'd0, 1'b0, 7'd9, 1'b0, 1'b0, 7'd0, 4'd1));
    step();
    chk("t4_p3", ra_data, {16{8'h33}});
    chk("t4_rc_unused", rc_data, 128'h0);
    pk[3] = '0;
    send(mk(7'd16, 7'd0, 1'b0, 7'd9, 1'b1, 7'd0, 1'b0, 1'b0, 7'd0, 4'd1));
    step();
    chk("t4_p6", rb_data, {16{8'h66}});
    pk[6] = '0;
    send(mk(7'd17, 7'd0, 1'b0, 7'd0, 1'b0, 7'd9, 1'b1, 1'b0, 7'd0, 4'd1));
    step();
    chk("t4_wb", rc_data, {16{8'h77}});
    wb_en = 1'b0;

    // 5. back-to-back dependency through stage 1
    send(mk(7'd18, 7'd0, 1'b0, 7'd0, 1'b0, 7'd0, 1'b0, 1'b1, 7'd7, 4'd2));
    send(mk(7'd19, 7'd7, 1'b1, 7'd0, 1'b0, 7'd0, 1'b0, 1'b0, 7'd0, 4'd1));
    chk("t5_a_wr", {reg_wr, reg_dst}, {1'b1, 7'd7});
    step();
    chk("t5_bubble", instr_id, LNOP);
    chk("t5_stall", stall_cycles, 16'd2);
    pk[2] = mkpk(1'b1, 7'd7, 4'd2, {16{8'h5A}});
    step();
    chk("t5_fwd", ra_data, {16{8'h5A}});
    chk("t5_id", instr_id, 7'd19);
    pk[2] = '0;

    // 6. flush during stall, with a new instruction offered
    pk[2] = mkpk(1'b1, 7'd12, 4'd5, {16{8'hEE}});
    send(mk(7'd20, 7'd12, 1'b1, 7'd0, 1'b0, 7'd0, 1'b0, 1'b0, 7'd0, 4'd1));
    step();
    step();
    chk("t6_stall", stall_cycles, 16'd4);
    flush = 1'b1;
    cur = mk(7'd21, 7'd3, 1'b1, 7'd0, 1'b0, 7'd0, 1'b0, 1'b0, 7'd0, 4'd1);
    in_valid = 1'b1;
    #1 chk("t6_flush_ready", in_ready, 1'b0);
    step();
    flush = 1'b0; in_valid = 1'b0; pk[2] = '0;
    step();
    step();
    chk("t6_no_issue_id", instr_id, LNOP);
    chk("t6_no_issue_wr", reg_wr, 1'b0);
    chk("t6_stall_kept", stall_cycles, 16'd4);

    // reset while stalled discards the entry
    pk[2] = mkpk(1'b1, 7'd12, 4'd5, {16{8'hEE}});
    send(mk(7'd22, 7'd12, 1'b1, 7'd0, 1'b0, 7'd0, 1'b0, 1'b0, 7'd0, 4'd1));
    step();
    rst = 1'b0;
    step();
    rst = 1'b1; pk[2] = '0;
    step();
    step();
    chk("rst_mid_id", instr_id, LNOP);
    chk("rst_mid_stall", stall_cycles, 16'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
